przesuniecie_prawo_sekw: RTL and testbench



---
 rtl/przesuniecie_pkg.sv | 60 ++++++
 rtl/przesuniecie_prawo_sekw_dekoder.sv | 48 ++++
 rtl/przesuniecie_prawo_sekw.sv | 154 +++++++++++++++
 tb/tb_przesuniecie_prawo_sekw.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/przesuniecie_pkg.sv
// ============================================================================
// Package : przesuniecie_pkg
// Purpose : Shared types and the shift-amount decode rule for the shift
//           blocks of the arithmetic unit. Both the combinational left
//           shifter and the sequential right shifter decode their amount
//           operand through decode_amount(), so they agree on what counts
//           as an error (negative amount) or an overflow (amount > width).
// Contents: state_t         - sequencer states of the sequential shifter
//           BITS_DEFAULT    - default operand width
//           MAX_BITS        - widest operand the decode function handles
//           dec_t           - decode result {error, overflow, amount}
//           decode_amount() - decode of the already inverted amount (~B)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package przesuniecie_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BITS_DEFAULT = 32;

  // Amounts are sign-extended to this width before decoding so that one
  // function serves every operand width up to MAX_BITS.
  localparam int MAX_BITS = 64;

  typedef struct packed {
    logic                error;     // amount is negative
    logic                overflow;  // amount exceeds the operand width
    logic [MAX_BITS-1:0] amount;    // valid amount, zero on error/overflow
  } dec_t;

  // n_ext : the encoded amount ~B, sign-extended to MAX_BITS.
  // bits  : operand width of the calling block.
  // Comparison is done on the full signed value; an amount equal to the
  // operand width is legal (it produces a pure sign fill).
  function automatic dec_t decode_amount(input logic signed [MAX_BITS-1:0] n_ext,
                                         input int                        bits);
    dec_t d;
    d.error    = 1'b0;
    d.overflow = 1'b0;
    d.amount   = '0;
    if (n_ext < 0) begin
      d.error = 1'b1;
    end else if (n_ext > longint'(bits)) begin
      d.overflow = 1'b1;
    end else begin
      d.amount = n_ext;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/przesuniecie_prawo_sekw_dekoder.sv
// ============================================================================
// Module  : dekoder_przesuniecia
// Purpose : Combinational decoder of the encoded shift-amount operand.
//           The amount is n = $signed(~b_i); the decode rule itself lives in
//           przesuniecie_pkg::decode_amount().
// Ports   : b_i        in  BITS   encoded amount operand (raw B)
//           n_o        out CNT_W  decoded amount, 0..BITS (0 on error/ovf)
//           error_o    out 1      n < 0
//           overflow_o out 1      n > BITS
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dekoder_przesuniecia
  import przesuniecie_pkg::*;
#(
  parameter int BITS  = BITS_DEFAULT,
  parameter int CNT_W = $clog2(BITS + 1)
) (
  input  logic [BITS-1:0]  b_i,
  output logic [CNT_W-1:0] n_o,
  output logic             error_o,
  output logic             overflow_o
);

  logic        [BITS-1:0]     w_n_raw;
  logic signed [MAX_BITS-1:0] w_n_ext;
  dec_t                       w_dec;
  logic                       w_unused_amount_hi;

  assign w_n_raw = ~b_i;

  // Sign-extend before the range check so that large negative or positive
  // encodings are never truncated into a small in-range value.
  assign w_n_ext = MAX_BITS'($signed(w_n_raw));

  assign w_dec = decode_amount(w_n_ext, BITS);

  // A legal amount never exceeds BITS, so only the low CNT_W bits carry
  // information; the upper bits are always zero here.
  assign n_o                = w_dec.amount[CNT_W-1:0];
  assign error_o            = w_dec.error;
  assign overflow_o         = w_dec.overflow;
  assign w_unused_amount_hi = ^w_dec.amount[MAX_BITS-1:CNT_W];

endmodule

`default_nettype wire

// File: rtl/przesuniecie_prawo_sekw.sv
// ============================================================================
// Module  : przesuniecie_prawo_sekw
// Purpose : Sequential arithmetic right shifter, one bit per clock.
//           A request is accepted in IDLE, the amount is decoded in LOAD,
//           the operand is shifted n times in SHIFT and the result is
//           presented with a one-cycle o_valid pulse in DONE.
//           Amount encoding: n = $signed(~i_arg_B).
// Ports   : i_clk      in  1     clock, rising edge
//           i_rst      in  1     synchronous active-high reset
//           i_start    in  1     request, sampled only in IDLE
//           i_arg_A    in  BITS  signed operand
//           i_arg_B    in  BITS  encoded shift amount
//           o_result   out BITS  result, held until the next LOAD
//           o_error    out 1     n < 0, held with the result
//           o_overflow out 1     n > BITS, held with the result
//           o_busy     out 1     high in LOAD and SHIFT
//           o_valid    out 1     one-cycle pulse in DONE
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module przesuniecie_prawo_sekw
  import przesuniecie_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic [BITS-1:0] o_result,
  output logic            o_error,
  output logic            o_overflow,
  output logic            o_busy,
  output logic            o_valid
);

  localparam int CNT_W = $clog2(BITS + 1);

  state_t            state_q;
  logic [BITS-1:0]   work_q;     // operand being shifted
  logic [BITS-1:0]   amt_q;      // captured ~B, decoded during LOAD
  logic [CNT_W-1:0]  cnt_q;      // shifts still to perform
  logic [BITS-1:0]   result_q;
  logic              error_q;
  logic              overflow_q;
  logic              busy_q;
  logic              valid_q;

  logic [CNT_W-1:0]  w_n;
  logic              w_error;
  logic              w_overflow;
  logic [BITS-1:0]   w_shifted;
  logic [BITS-1:0]   w_sign_fill;

  // The decoder expects the raw B encoding, while the register holds ~B;
  // inverting again restores B.
  dekoder_przesuniecia #(
    .BITS  (BITS),
    .CNT_W (CNT_W)
  ) u_dekoder (
    .b_i        (~amt_q),
    .n_o        (w_n),
    .error_o    (w_error),
    .overflow_o (w_overflow)
  );

  // Arithmetic shift by one: the sign bit is replicated into the MSB.
  assign w_shifted   = {work_q[BITS-1], work_q[BITS-1:1]};
  assign w_sign_fill = {BITS{work_q[BITS-1]}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      amt_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            work_q  <= i_arg_A;
            amt_q   <= ~i_arg_B;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end

        LOAD: begin
          // Flags and result of the previous operation are replaced here.
          error_q    <= w_error;
          overflow_q <= w_overflow;
          if (w_error) begin
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else if (w_overflow) begin
            result_q <= w_sign_fill;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else if (w_n == '0) begin
            result_q <= work_q;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            result_q <= '0;
            cnt_q    <= w_n;
            state_q  <= SHIFT;
          end
        end

        SHIFT: begin
          work_q <= w_shifted;
          cnt_q  <= cnt_q - 1'b1;
          // Last shift: publish the shifted value directly so the result is
          // ready in the DONE cycle.
          if (cnt_q == CNT_W'(1)) begin
            result_q <= w_shifted;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_result   = result_q;
  assign o_error    = error_q;
  assign o_overflow = overflow_q;
  assign o_busy     = busy_q;
  assign o_valid    = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_przesuniecie_prawo_sekw.sv
// ============================================================================
// Module  : tb_przesuniecie_prawo_sekw
// Purpose : Directed self-checking bench for przesuniecie_prawo_sekw, BITS=32.
//           Latency k is counted in cycles after the start edge t
//           (k=1 is the LOAD cycle), sampled on the falling clock edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_przesuniecie_prawo_sekw;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [31:0] i_arg_A;
  logic [31:0] i_arg_B;
  logic [31:0] o_result;
  logic        o_error;
  logic        o_overflow;
  logic        o_busy;
  logic        o_valid;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_cnt;

  przesuniecie_prawo_sekw #(.BITS(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (i_start),
    .i_arg_A    (i_arg_A),
    .i_arg_B    (i_arg_B),
    .o_result   (o_result),
    .o_error    (o_error),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_valid    (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] exp_res);
    check({tag, "_result"}, o_result, exp_res);
    check({tag, "_error"}, 32'(o_error), 32'd0);
    check({tag, "_overflow"}, 32'(o_overflow), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
  endtask

  // Issues one request and waits (bounded) for o_valid. Returns with time at
  // the falling edge of the valid cycle; lat = -1 if no valid was seen.
  // pulse_at: cycle k in which a stray start with other operands is driven.
  // rst_at  : cycle k in which reset is driven; outputs are checked at k+1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input int rst_at,
                        output int lat_o, output int busy_o);
    @(negedge clk);
    i_start = 1'b1;
    i_arg_A = a;
    i_arg_B = b;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_arg_A = 32'hDEAD_BEEF;
    i_arg_B = 32'h0000_0000;
    lat_o  = -1;
    busy_o = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      rst     = 1'b0;
      if (o_busy) busy_o++;
      if (rst_at != 0 && k == rst_at + 1) begin
        check_idle_outputs("reset_midshift", 32'h0);
      end
      if (o_valid) begin
        lat_o = k;
        break;
      end
      if (k == rst_at) rst = 1'b1;
      if (k == pulse_at) begin
        i_start = 1'b1;
        i_arg_A = 32'h0000_00FF;
        i_arg_B = ~32'd1;
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    i_arg_A = 32'h0;
    i_arg_B = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 32'h0);
    rst = 1'b0;

    // n = 4, negative operand
    run_op(32'h8000_0000, ~32'd4, 0, 0, lat, busy_cnt);
    check("n4_latency", 32'(lat), 32'd6);
    check("n4_busy_cycles", 32'(busy_cnt), 32'd5);
    check("n4_result", o_result, 32'hF800_0000);
    check("n4_error", 32'(o_error), 32'd0);
    check("n4_overflow", 32'(o_overflow), 32'd0);
    check("n4_busy_in_done", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("n4_valid_one_cycle", 32'(o_valid), 32'd0);
    check("n4_result_held", o_result, 32'hF800_0000);

    // n = 0
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, busy_cnt);
    check("n0_latency", 32'(lat), 32'd2);
    check("n0_result", o_result, 32'h7FFF_FFFF);
    check("n0_error", 32'(o_error), 32'd0);

    // n = -3 -> error
    run_op(32'h1234_5678, 32'h0000_0002, 0, 0, lat, busy_cnt);
    check("neg_latency", 32'(lat), 32'd2);
    check("neg_error", 32'(o_error), 32'd1);
    check("neg_overflow", 32'(o_overflow), 32'd0);
    check("neg_result", o_result, 32'h0);

    // n = 40 -> overflow, sign fill
    run_op(32'h8000_0001, ~32'd40, 0, 0, lat, busy_cnt);
    check("ovf_latency", 32'(lat), 32'd2);
    check("ovf_overflow", 32'(o_overflow), 32'd1);
    check("ovf_error", 32'(o_error), 32'd0);
    check("ovf_result", o_result, 32'hFFFF_FFFF);

    // n = 32 -> legal, full sign fill of positive operand
    run_op(32'h7FFF_FFFF, ~32'd32, 0, 0, lat, busy_cnt);
    check("n32_latency", 32'(lat), 32'd34);
    check("n32_result", o_result, 32'h0);
    check("n32_overflow", 32'(o_overflow), 32'd0);
    check("n32_error", 32'(o_error), 32'd0);

    // n = 8 with a stray start during SHIFT
    run_op(32'hF000_0000, ~32'd8, 3, 0, lat, busy_cnt);
    check("ign_latency", 32'(lat), 32'd10);
    check("ign_result", o_result, 32'hFFF0_0000);
    repeat (2) @(negedge clk);
    check("ign_no_second_op_busy", 32'(o_busy), 32'd0);
    check("ign_no_second_op_valid", 32'(o_valid), 32'd0);
    check("ign_result_held", o_result, 32'hFFF0_0000);

    // Reset during SHIFT: discarded, no valid pulse
    run_op(32'h8000_0000, ~32'd8, 0, 5, lat, busy_cnt);
    check("rst_no_valid", 32'(lat), 32'hFFFF_FFFF);
    check_idle_outputs("rst_after", 32'h0);

    // Fresh operation after reset
    run_op(32'h4000_0000, ~32'd2, 0, 0, lat, busy_cnt);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_result", o_result, 32'h1000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
